// File: rtl/pulse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pulse_pkg                                                    |
// | Description : Shared types and helpers for the pulse sequencer: state      |
// |               encoding, the shadow-parameter bundle and the segment        |
// |               resolution helpers that skip zero-length segments.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pulse_pkg;

    // Default period granularity: one period count = 2**PERIOD_SHIFT cycles.
    localparam int unsigned PERIOD_SHIFT = 16;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        NUT  = 4'd1,
        NUTD = 4'd2,
        P1   = 4'd3,
        DEL  = 4'd4,
        P2   = 4'd5,
        ECHO = 4'd6,
        HOLD = 4'd7,
        WAIT = 4'd8
    } state_t;

    // Parameter inputs frozen at the start of each period. The refocusing
    // count is not kept here; it seeds the P2 down-counter directly.
    typedef struct packed {
        logic [7:0]  per;
        logic [15:0] p1wid;
        logic [15:0] del;
        logic [15:0] p2wid;
        logic        pu;
        logic        bl;
        logic [7:0]  p_bl;
        logic        nut;
        logic [31:0] nut_w;
        logic [31:0] nut_d;
    } shadow_t;

    // Result of resolving "which segment comes next": the state to enter
    // and the number of P2 pulses still to be issued after that choice.
    // WAIT in the state field means the sequence has finished.
    typedef struct packed {
        state_t     state;
        logic [7:0] p2_left;
    } seg_sel_t;

    function automatic logic is_pulse(input state_t s);
        return (s == NUT) || (s == P1) || (s == P2);
    endfunction

    function automatic logic is_seg(input state_t s);
        return (s != IDLE) && (s != WAIT);
    endfunction

    // Next segment once a P2 has been issued (or skipped). If both the echo
    // and the P2 lengths are zero, every remaining repetition is empty, so the
    // loop collapses straight to the tail.
    function automatic seg_sel_t after_p2(input logic [7:0] left,
                                          input logic       del_nz,
                                          input logic       p2_nz,
                                          input logic       hold_nz);
        seg_sel_t sel;
        sel.p2_left = left;
        sel.state   = hold_nz ? HOLD : WAIT;
        if (left != 8'd0) begin
            if (del_nz) begin
                sel.state = ECHO;
            end else if (p2_nz) begin
                sel.state   = P2;
                sel.p2_left = left - 8'd1;
            end
        end
        return sel;
    endfunction

    // Issue the next P2; a zero-width P2 still counts as issued.
    function automatic seg_sel_t p2_entry(input logic [7:0] left,
                                          input logic       del_nz,
                                          input logic       p2_nz,
                                          input logic       hold_nz);
        seg_sel_t sel;
        if (left == 8'd0) begin
            sel = after_p2(8'd0, del_nz, p2_nz, hold_nz);
        end else if (p2_nz) begin
            sel.state   = P2;
            sel.p2_left = left - 8'd1;
        end else begin
            sel = after_p2(left - 8'd1, del_nz, p2_nz, hold_nz);
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_timer                                                    |
// | Description : Loadable 32-bit down-counter timing one sequence segment.    |
// |               o_done is high on the last cycle of the loaded length.       |
// | Ports       : clk, rst        - clock, synchronous active-high reset       |
// |               i_load          - load i_load_val on this edge               |
// |               i_load_val[31:0]- segment length in cycles                   |
// |               o_done          - current cycle is the segment's last        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    output logic        o_done
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Holds at zero rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // A count of 1 marks the final cycle; 0 is treated the same so a segment
    // can never stall.
    assign o_done = (count_q <= 32'd1);

endmodule
`default_nettype wire

// File: rtl/pulse_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pulse_sequencer                                              |
// | Description : Periodic pulse-train generator (optional nutation pulse,     |
// |               P1, then cp refocusing P2 pulses spaced by echo delays)      |
// |               with RF gate, receiver blocking and a period-start strobe.   |
// | Ports       : clk, rst               - clock, sync active-high reset       |
// |               per[7:0]               - period count (<< PERIOD_SHIFT)      |
// |               p1wid/del/p2wid[15:0]  - P1 width, delay, P2 width           |
// |               cp[7:0]                - refocusing count (0 acts as 1)      |
// |               pu, bl, p_bl[7:0]      - pump, block enable, block hold-off  |
// |               nut, nut_w/nut_d[31:0] - nutation enable, width, delay       |
// |               sync, pulse, block, busy - registered outputs                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pulse_sequencer
    import pulse_pkg::*;
#(
    parameter int unsigned PERIOD_SHIFT = pulse_pkg::PERIOD_SHIFT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  per,
    input  logic [15:0] p1wid,
    input  logic [15:0] del,
    input  logic [15:0] p2wid,
    input  logic [7:0]  cp,
    input  logic        pu,
    input  logic        bl,
    input  logic [7:0]  p_bl,
    input  logic        nut,
    input  logic [31:0] nut_w,
    input  logic [31:0] nut_d,
    output logic        sync,
    output logic        pulse,
    output logic        block,
    output logic        busy
);

    state_t      state_q,   state_d;
    shadow_t     sh_q,      sh_d;
    logic [31:0] cnt_q,     cnt_d;
    logic [7:0]  p2_left_q, p2_left_d;
    logic        sync_q,    sync_d;
    logic        pulse_q,   pulse_d;
    logic        block_q,   block_d;
    logic        busy_q,    busy_d;
    logic        arm_q,     arm_d;

    logic        w_seg_done;
    logic        w_load;
    logic [31:0] w_load_val;
    logic        w_advance;
    logic        w_start_period;
    seg_sel_t    w_sel;

    logic        w_del_nz, w_p1_nz, w_p2_nz, w_hold_nz, w_nutw_nz, w_nutd_nz;
    logic [7:0]  w_cp_eff;
    logic [31:0] w_cnt_inc;
    logic [31:0] w_per_len;
    logic        w_per_hit;
    seg_sel_t    w_p2_entry, w_after_p2;
    seg_sel_t    w_from_p1, w_from_nutd, w_from_nut, w_start;

    seg_timer u_seg_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_seg_done)
    );

    assign w_del_nz  = (sh_q.del   != 16'd0);
    assign w_p1_nz   = (sh_q.p1wid != 16'd0);
    assign w_p2_nz   = (sh_q.p2wid != 16'd0);
    assign w_nutw_nz = (sh_q.nut_w != 32'd0);
    assign w_nutd_nz = (sh_q.nut_d != 32'd0);
    // The hold-off only exists to extend blocking; without blocking it has no
    // purpose and takes no time.
    assign w_hold_nz = sh_q.bl && (sh_q.p_bl != 8'd0);

    assign w_cp_eff  = (cp == 8'd0) ? 8'd1 : cp;

    // cnt_q equals the cycle offset from the last sync; w_cnt_inc is the
    // offset of the next cycle, saturated so it never wraps.
    assign w_cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    assign w_per_len = 32'(sh_q.per) << PERIOD_SHIFT;
    assign w_per_hit = (w_cnt_inc >= w_per_len);

    assign w_p2_entry = p2_entry(p2_left_q, w_del_nz, w_p2_nz, w_hold_nz);
    assign w_after_p2 = after_p2(p2_left_q, w_del_nz, w_p2_nz, w_hold_nz);

    // First non-empty segment at or after each entry point of the sequence.
    always_comb begin
        w_from_p1 = w_p2_entry;
        if (w_p1_nz) begin
            w_from_p1 = '{state: P1, p2_left: p2_left_q};
        end else if (w_del_nz) begin
            w_from_p1 = '{state: DEL, p2_left: p2_left_q};
        end

        w_from_nutd = w_nutd_nz ? seg_sel_t'{state: NUTD, p2_left: p2_left_q} : w_from_p1;
        w_from_nut  = w_nutw_nz ? seg_sel_t'{state: NUT,  p2_left: p2_left_q} : w_from_nutd;
        w_start     = sh_q.nut  ? w_from_nut : w_from_p1;
    end

    // Next-state, period bookkeeping and output decode.
    always_comb begin
        w_sel          = '{state: state_q, p2_left: p2_left_q};
        w_advance      = 1'b0;
        w_start_period = 1'b0;
        state_d        = state_q;
        sh_d           = sh_q;
        cnt_d          = w_cnt_inc;
        p2_left_d      = p2_left_q;
        sync_d         = 1'b0;

        case (state_q)
            IDLE: begin
                // IDLE with sync_q set is the T0 cycle: shadows are fresh.
                // Without sync_q we have just left reset: start a period.
                if (sync_q) begin
                    w_sel     = w_start;
                    w_advance = 1'b1;
                end else begin
                    w_start_period = 1'b1;
                end
            end
            NUT: begin
                if (w_seg_done) begin
                    w_sel     = w_from_nutd;
                    w_advance = 1'b1;
                end
            end
            NUTD: begin
                if (w_seg_done) begin
                    w_sel     = w_from_p1;
                    w_advance = 1'b1;
                end
            end
            P1: begin
                if (w_seg_done) begin
                    w_sel     = w_del_nz ? seg_sel_t'{state: DEL, p2_left: p2_left_q} : w_p2_entry;
                    w_advance = 1'b1;
                end
            end
            DEL, ECHO: begin
                if (w_seg_done) begin
                    w_sel     = w_p2_entry;
                    w_advance = 1'b1;
                end
            end
            P2: begin
                if (w_seg_done) begin
                    w_sel     = w_after_p2;
                    w_advance = 1'b1;
                end
            end
            HOLD: begin
                if (w_seg_done) begin
                    w_sel     = '{state: WAIT, p2_left: p2_left_q};
                    w_advance = 1'b1;
                end
            end
            WAIT: begin
                if (w_per_hit) begin
                    w_start_period = 1'b1;
                end
            end
            default: begin
                w_start_period = 1'b1;
            end
        endcase

        if (w_advance) begin
            state_d   = w_sel.state;
            p2_left_d = w_sel.p2_left;
            // Sequence finished exactly as the period expires: skip WAIT.
            if ((w_sel.state == WAIT) && w_per_hit) begin
                w_start_period = 1'b1;
            end
        end

        if (w_start_period) begin
            state_d   = IDLE;
            sync_d    = 1'b1;
            cnt_d     = 32'd0;
            p2_left_d = w_cp_eff;
            sh_d      = '{per: per, p1wid: p1wid, del: del, p2wid: p2wid,
                          pu: pu, bl: bl, p_bl: p_bl,
                          nut: nut, nut_w: nut_w, nut_d: nut_d};
        end

        // Outputs are decoded from the state being entered so the registered
        // outputs line up with the state register.
        busy_d  = is_seg(state_d);
        pulse_d = sh_q.pu && is_pulse(state_d);
        // Blocking arms on the first pulse cycle and lasts to the end of HOLD.
        arm_d   = is_seg(state_d) && (arm_q || is_pulse(state_d));
        block_d = sh_q.bl && arm_d;
    end

    // Timer reload on every segment change; length taken from the shadows.
    assign w_load = w_advance || w_start_period;

    always_comb begin
        case (state_d)
            NUT:     w_load_val = sh_q.nut_w;
            NUTD:    w_load_val = sh_q.nut_d;
            P1:      w_load_val = {16'd0, sh_q.p1wid};
            DEL:     w_load_val = {16'd0, sh_q.del};
            P2:      w_load_val = {16'd0, sh_q.p2wid};
            ECHO:    w_load_val = {15'd0, sh_q.del, 1'b0};   // 2*del, 17 bits
            HOLD:    w_load_val = {24'd0, sh_q.p_bl};
            default: w_load_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            cnt_q     <= 32'd0;
            p2_left_q <= 8'd0;
            sync_q    <= 1'b0;
            pulse_q   <= 1'b0;
            block_q   <= 1'b0;
            busy_q    <= 1'b0;
            arm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            p2_left_q <= p2_left_d;
            sync_q    <= sync_d;
            pulse_q   <= pulse_d;
            block_q   <= block_d;
            busy_q    <= busy_d;
            arm_q     <= arm_d;
        end
    end

    assign sync  = sync_q;
    assign pulse = pulse_q;
    assign block = block_q;
    assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pulse_sequencer                                           |
// | Description : Self-checking bench: directed and random parameter sets,     |
// |               each period compared cycle by cycle against a segment-list   |
// |               reference model; also reset behaviour.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pulse_sequencer;

    localparam int SHIFT = 4;
    localparam int MAXC  = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  per;
    logic [15:0] p1wid, del, p2wid;
    logic [7:0]  cp;
    logic        pu, bl;
    logic [7:0]  p_bl;
    logic        nut;
    logic [31:0] nut_w, nut_d;
    logic        sync, pulse, block, busy;

    pulse_sequencer #(.PERIOD_SHIFT(SHIFT)) dut (
        .clk   (clk),   .rst   (rst),
        .per   (per),   .p1wid (p1wid), .del   (del),   .p2wid (p2wid),
        .cp    (cp),    .pu    (pu),    .bl    (bl),    .p_bl  (p_bl),
        .nut   (nut),   .nut_w (nut_w), .nut_d (nut_d),
        .sync  (sync),  .pulse (pulse), .block (block), .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int per, p1wid, del, p2wid, cp, pu, bl, p_bl, nut, nut_w, nut_d;
    } prm_t;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_pulse [MAXC];
    bit exp_block [MAXC];
    bit exp_busy  [MAXC];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input prm_t p);
        per   = 8'(p.per);
        p1wid = 16'(p.p1wid);
        del   = 16'(p.del);
        p2wid = 16'(p.p2wid);
        cp    = 8'(p.cp);
        pu    = 1'(p.pu);
        bl    = 1'(p.bl);
        p_bl  = 8'(p.p_bl);
        nut   = 1'(p.nut);
        nut_w = 32'(p.nut_w);
        nut_d = 32'(p.nut_d);
    endtask

    // Reference: list the segments of one period in order (empty ones just
    // contribute no cycles), lay them out from offset 1, then derive outputs.
    task automatic plan(input prm_t p, output int seq_len, output int next_sync);
        int seg_len[$];
        bit seg_pls[$];
        int t, first, cpe;
        if (p.nut != 0) begin
            seg_len.push_back(p.nut_w); seg_pls.push_back(1'b1);
            seg_len.push_back(p.nut_d); seg_pls.push_back(1'b0);
        end
        seg_len.push_back(p.p1wid); seg_pls.push_back(1'b1);
        seg_len.push_back(p.del);   seg_pls.push_back(1'b0);
        cpe = (p.cp == 0) ? 1 : p.cp;
        for (int i = 0; i < cpe; i++) begin
            if (i > 0) begin
                seg_len.push_back(2 * p.del); seg_pls.push_back(1'b0);
            end
            seg_len.push_back(p.p2wid); seg_pls.push_back(1'b1);
        end
        seg_len.push_back((p.bl != 0) ? p.p_bl : 0); seg_pls.push_back(1'b0);

        for (int k = 0; k < MAXC; k++) exp_pulse[k] = 1'b0;
        t     = 1;
        first = -1;
        foreach (seg_len[i]) begin
            for (int c = 0; c < seg_len[i]; c++) begin
                if (seg_pls[i]) begin
                    exp_pulse[t] = (p.pu != 0);
                    if (first < 0) first = t;
                end
                t++;
            end
        end
        seq_len = t - 1;
        for (int k = 0; k < MAXC; k++) begin
            exp_busy[k]  = (k >= 1) && (k <= seq_len);
            exp_block[k] = (p.bl != 0) && (first >= 0) && (k >= first) && (k <= seq_len);
        end
        next_sync = p.per << SHIFT;
        if (next_sync < seq_len + 1) next_sync = seq_len + 1;
    endtask

    // Entered at the falling edge of a sync cycle; returns at the falling edge
    // of the next sync cycle. Inputs switch to nxt at offset chg_k; when
    // rst_k >= 0, reset is pulsed at that offset instead of finishing.
    task automatic run_period(input prm_t cur, input prm_t nxt, input int chg_k, input int rst_k);
        int len, plen, ck;
        plan(cur, len, plen);
        ck = (chg_k < plen) ? chg_k : plen - 1;
        for (int k = 0; k < plen; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("sync@%0d", k),  sync,  32'(k == 0));
            check($sformatf("pulse@%0d", k), pulse, 32'(exp_pulse[k]));
            check($sformatf("block@%0d", k), block, 32'(exp_block[k]));
            check($sformatf("busy@%0d", k),  busy,  32'(exp_busy[k]));
            if (k == ck) apply(nxt);
            if (k == rst_k) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_mid_pulse", pulse, 32'd0);
                check("rst_mid_block", block, 32'd0);
                check("rst_mid_sync",  sync,  32'd0);
                check("rst_mid_busy",  busy,  32'd0);
                rst = 1'b0;
                @(negedge clk);
                return;
            end
        end
        @(negedge clk);
    endtask

    function automatic int rnd_len(input int max);
        if ($urandom_range(0, 4) == 0) return 0;
        return int'($urandom_range(1, max));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        prm_t q[$];
        prm_t hahn, p, hb;

        hahn = '{per:0, p1wid:30, del:200, p2wid:30, cp:1, pu:1, bl:0, p_bl:0,
                 nut:0, nut_w:0, nut_d:0};
        q.push_back(hahn);                                        // Hahn echo
        p = hahn; p.per = 20;                     q.push_back(p); // period 320 > 261
        p = hahn; p.cp = 3;                       q.push_back(p); // CPMG
        p = hahn; p.nut = 1; p.nut_w = 300; p.nut_d = 300;
        q.push_back(p);                                           // nutation
        p = hahn; p.pu = 0; p.bl = 1; p.p_bl = 50; q.push_back(p); // pump off, block
        p.p1wid = 60;                             q.push_back(p); // mid-period update
        p = '{per:3, p1wid:10, del:0, p2wid:5, cp:0, pu:1, bl:1, p_bl:0,
              nut:0, nut_w:0, nut_d:0};           q.push_back(p); // cp=0, no delay
        p = '{per:0, p1wid:0, del:9, p2wid:4, cp:2, pu:1, bl:1, p_bl:3,
              nut:1, nut_w:0, nut_d:7};           q.push_back(p); // zero-length skips
        p = '{per:0, p1wid:5, del:3, p2wid:0, cp:3, pu:1, bl:1, p_bl:2,
              nut:0, nut_w:0, nut_d:0};           q.push_back(p); // empty P2 pulses
        for (int i = 0; i < 25; i++) begin
            p.nut   = int'($urandom_range(0, 1));
            p.nut_w = rnd_len(60);
            p.nut_d = rnd_len(60);
            p.p1wid = rnd_len(40);
            p.del   = rnd_len(60);
            p.p2wid = rnd_len(30);
            p.cp    = int'($urandom_range(0, 4));
            p.pu    = int'($urandom_range(0, 1));
            p.bl    = int'($urandom_range(0, 1));
            p.p_bl  = rnd_len(20);
            p.per   = int'($urandom_range(0, 40));
            q.push_back(p);
        end
        hb = hahn; hb.bl = 1; hb.p_bl = 5;
        q.push_back(hb);

        rst = 1'b1;
        apply(q[0]);
        repeat (3) @(negedge clk);
        check("reset_sync",  sync,  32'd0);
        check("reset_pulse", pulse, 32'd0);
        check("reset_block", block, 32'd0);
        check("reset_busy",  busy,  32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < q.size() - 1; i++) begin
            run_period(q[i], q[i + 1], (i < 9) ? 100 : int'($urandom_range(1, 60)), -1);
        end
        run_period(hb, hb, 1, 10);
        run_period(hb, hb, 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_sequencer.md
PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 SHALL have the parameter PERIOD_SHIFT, default 16, which sets the period length as per << PERIOD_SHIFT clock cycles.
REQ-002 SHALL have one clock and synchronous active-high reset, with these ports: clk input 1, the 201 MHz master clock; rst input 1, the synchronous active-high reset.
REQ-003 SHALL have these parameter inputs: per input 8, period count; p1wid input 16, first-pulse width in cycles; del input 16, pulse-to-pulse delay in cycles; p2wid input 16, refocusing-pulse width in cycles.
REQ-004 SHALL have these control inputs: cp input 8, refocusing-pulse count; pu input 1, pump enable; bl input 1, receiver-block enable; p_bl input 8, block hold-off after the last pulse in cycles.
REQ-005 SHALL have these nutation inputs: nut input 1, nutation enable; nut_w input 32, nutation width in cycles; nut_d input 32, nutation-to-P1 delay in cycles.
REQ-006 SHALL have these outputs: sync output 1, one-cycle strobe at period start; pulse output 1, RF gate; block output 1, receiver protection; busy output 1, high while a sequence is in progress.

Function
REQ-007 SHALL latch all parameter inputs into shadow registers only on the cycle sync is high; input changes mid-period SHALL have no effect until the next period.
REQ-008 SHALL use these states: IDLE, NUT, NUTD, P1, DEL, P2, ECHO, HOLD, WAIT.
REQ-009 SHALL follow this sequence in one period: sync at T0; from T0+1, NUT (nut_w cycles), then NUTD (nut_d cycles), then P1 (p1wid), then DEL (del), then P2 (p2wid).
REQ-010 SHALL repeat [ECHO (2*del cycles), P2 (p2wid)] until cp P2 pulses have been issued; cp=0 SHALL be treated as 1.
REQ-011 SHALL skip NUT and NUTD when shadow nut=0, so P1 begins at T0+1.
REQ-012 SHALL skip any segment whose shadow length is 0 without spending a cycle in it.
REQ-013 SHALL drive pulse high exactly during NUT, P1 and P2 when shadow pu=1; when pu=0, pulse SHALL stay low but all timing SHALL be unchanged.
REQ-014 SHALL, when shadow bl=1, drive block high from the first cycle of the first pulse state through p_bl cycles after the last P2 (the HOLD state); when bl=0, block SHALL stay 0.
REQ-015 SHALL run a 32-bit period counter from T0; the next sync SHALL occur at cycle T0 + max(per << PERIOD_SHIFT, sequence length + 1).
REQ-016 SHALL treat per=0 as a minimum period, so the next sync follows the sequence end by exactly 1 cycle.
REQ-017 SHALL compute 2*del as a 17-bit value without overflow; the segment counter SHALL be 32 bits, down-counting, and SHALL never wrap.
REQ-018 SHALL register outputs pulse, block and sync with no combinational path from inputs.
REQ-019 SHALL keep busy high from T0+1 until the WAIT state is entered.

Reset
REQ-020 SHALL, with rst high, drive sync, pulse, block and busy to 0 and hold the state machine in IDLE with both counters cleared.
REQ-021 SHALL, after rst deasserts, issue the first sync on the first clk edge after rst is sampled low.
REQ-022 SHALL, on rst mid-sequence, force pulse and block low on the next cycle.

Structure
REQ-023 SHALL put the state enumeration and PERIOD_SHIFT in the shared package pulse_pkg.
REQ-024 SHALL implement segment timing in one sub-module, seg_timer, a loadable 32-bit down-counter with a done flag.

Verification
REQ-025 SHALL cover Hahn echo: nut=0, pu=1, bl=0, p1wid=30, del=200, p2wid=30, cp=1 -> pulse high T0+1..T0+30 and T0+231..T0+260, and block stays 0.
REQ-026 SHALL cover CPMG: cp=3 with the values of REQ-025 -> P2 pulses start at T0+231, T0+661 and T0+1091, each 30 cycles wide.
REQ-027 SHALL cover nutation: nut=1, nut_w=300, nut_d=300 -> pulse high T0+1..T0+300 and P1 starts at T0+601.
REQ-028 SHALL cover pump off and blocking: pu=0, bl=1, p_bl=50, cp=1 -> pulse stays 0 and block is high T0+1..T0+310.
REQ-029 SHALL cover mid-period update and overrun: change p1wid to 60 at T0+100 -> current period unchanged and next period P1 is 60 cycles; with per=0 -> the next sync occurs 1 cycle after the sequence ends.
REQ-030 SHALL cover reset mid-pulse: rst at T0+10 -> pulse is 0 at T0+11 and sync is re-issued 1 cycle after rst release.
